// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage.
// FSM states, control bundle and default timeout.
package mem_stage_pkg;

  localparam int MAX_WAIT_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic       PCSrc;
    logic       RegWrite;
    logic       MemtoReg;
    logic       MemWrite;
    logic [3:0] Rd;
  } mem_ctrl_t;

endpackage

// File: rtl/mem_wait_ctr.sv
// Wait-cycle counter for an outstanding memory request.
// tc_o flags the last permitted wait cycle.
module mem_wait_ctr
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_stage_access.sv
// Memory stage: drives the data bus, stalls while busy,
// and registers results into the writeback stage.
module mem_stage_access
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCSrcM,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic [3:0]        RdM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              StallM,
  output logic              PCSrcW,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic [3:0]        RdW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] ALUOutW,
  output logic              MemErrW
);

  mem_state_t  state_q, state_d;
  mem_ctrl_t   ctrl_q, ctrl_d;
  logic        req_q, req_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic        pcsrc_q, pcsrc_d;
  logic        regw_q, regw_d;
  logic        m2r_q, m2r_d;
  logic [3:0]  rd_q, rd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic        err_q, err_d;

  logic memop, start, done, abort;
  logic stall, cnt_clr, cnt_en, tc;

  assign memop = MemtoRegM | MemWriteM;

  mem_wait_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_ctr (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (tc)
  );

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    start   = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (memop) begin
          stall   = 1'b1;
          start   = 1'b1;
          cnt_clr = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (tc) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          stall  = 1'b1;
          cnt_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request side: operands are captured once and held for all of REQ.
  always_comb begin
    ctrl_d  = ctrl_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    req_d   = req_q;
    if (start) begin
      ctrl_d  = '{PCSrc: PCSrcM, RegWrite: RegWriteM,
                  MemtoReg: MemtoRegM, MemWrite: MemWriteM,
                  Rd: RdM};
      addr_d  = ALUResultM;
      wdata_d = WriteDataM;
      req_d   = 1'b1;
    end else if (done || abort) begin
      req_d = 1'b0;
    end
  end

  // Writeback side: control defaults to a bubble.
  always_comb begin
    pcsrc_d = 1'b0;
    regw_d  = 1'b0;
    m2r_d   = 1'b0;
    rd_d    = rd_q;
    alu_d   = alu_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    if (state_q == IDLE && !memop) begin
      pcsrc_d = PCSrcM;
      regw_d  = RegWriteM;
      m2r_d   = MemtoRegM;
      rd_d    = RdM;
      alu_d   = ALUResultM;
    end else if (done) begin
      pcsrc_d = ctrl_q.PCSrc;
      regw_d  = ctrl_q.RegWrite;
      m2r_d   = ctrl_q.MemtoReg;
      rd_d    = ctrl_q.Rd;
      alu_d   = addr_q;
      if (ctrl_q.MemtoReg)
        rdata_d = mem_rdata;
    end else if (abort) begin
      err_d = 1'b1;
      rd_d  = ctrl_q.Rd;
      alu_d = addr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      pcsrc_q <= 1'b0;
      regw_q  <= 1'b0;
      m2r_q   <= 1'b0;
      rd_q    <= '0;
      rdata_q <= '0;
      alu_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pcsrc_q <= pcsrc_d;
      regw_q  <= regw_d;
      m2r_q   <= m2r_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      err_q   <= err_d;
    end
  end

  // Stall must drop the instant reset asserts, even with a memop held upstream.
  assign StallM    = stall & ~reset;
  assign mem_req   = req_q;
  assign mem_we    = ctrl_q.MemWrite;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign PCSrcW    = pcsrc_q;
  assign RegWriteW = regw_q;
  assign MemtoRegW = m2r_q;
  assign RdW       = rd_q;
  assign ReadDataW = rdata_q;
  assign ALUOutW   = alu_q;
  assign MemErrW   = err_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed bench for mem_stage_access with MAX_WAIT=4.
module tb_mem_stage_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
  logic [3:0]  RdM;
  logic [31:0] ALUResultM, WriteDataM;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        StallM, PCSrcW, RegWriteW, MemtoRegW, MemErrW;
  logic [3:0]  RdW;
  logic [31:0] ReadDataW, ALUOutW;

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;

  mem_stage_access #(
    .MAX_WAIT (4),
    .DATA_W   (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .PCSrcM     (PCSrcM),
    .RegWriteM  (RegWriteM),
    .MemtoRegM  (MemtoRegM),
    .MemWriteM  (MemWriteM),
    .RdM        (RdM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .StallM     (StallM),
    .PCSrcW     (PCSrcW),
    .RegWriteW  (RegWriteW),
    .MemtoRegW  (MemtoRegW),
    .RdW        (RdW),
    .ReadDataW  (ReadDataW),
    .ALUOutW    (ALUOutW),
    .MemErrW    (MemErrW)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_req && mem_ready) acc_cnt++;

  task automatic drive(input logic pc, input logic rw,
                       input logic m2r, input logic mw,
                       input logic [3:0] rd,
                       input logic [31:0] alu,
                       input logic [31:0] wd);
    PCSrcM = pc; RegWriteM = rw; MemtoRegM = m2r;
    MemWriteM = mw; RdM = rd; ALUResultM = alu;
    WriteDataM = wd;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    drive(0, 1, 1, 0, 4'h6, 32'h80, 32'h0);
    mem_ready = 1'b0;
    step();
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_req got=%b exp=1", mem_req);
    end
    reset = 1'b1; #1;
    checks++;
    if ({mem_req, StallM, mem_we} !== 3'b000) begin
      failures++;
      $display("FAIL rst_req_stall got=%b exp=000",
               {mem_req, StallM, mem_we});
    end
    checks++;
    if ({PCSrcW, RegWriteW, MemtoRegW, MemErrW, RdW} !== 8'h00
        || ReadDataW !== 32'h0 || ALUOutW !== 32'h0
        || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_w_outs got=%h %h %h %h exp=0",
               {PCSrcW, RegWriteW, MemtoRegW, MemErrW, RdW},
               ReadDataW, ALUOutW, mem_addr);
    end
    drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_alu;
    drive(0, 1, 0, 0, 4'h3, 32'h0000_00AA, 32'h0);
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    if (StallM !== 1'b0) begin
      failures++;
      $display("FAIL alu_stall got=%b exp=0", StallM);
    end
    step();
    mem_ready = 1'b0;
    drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (RegWriteW !== 1'b1 || RdW !== 4'h3 || ALUOutW !== 32'hAA) begin
      failures++;
      $display("FAIL alu_w got=%b %h %h exp=1 3 000000aa",
               RegWriteW, RdW, ALUOutW);
    end
    checks++;
    if (ReadDataW !== 32'h0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_ready_ignored got=%h %b exp=0 0",
               ReadDataW, mem_req);
    end
  endtask

  task automatic test_load;
    drive(0, 1, 1, 0, 4'h5, 32'h100, 32'h0);
    @(negedge clk);
    checks++;
    if (StallM !== 1'b1) begin
      failures++;
      $display("FAIL ld_stall_detect got=%b exp=1", StallM);
    end
    step();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 ||
        mem_we !== 1'b0 || StallM !== 1'b1) begin
      failures++;
      $display("FAIL ld_req1 got=%b %h %b %b exp=1 100 0 1",
               mem_req, mem_addr, mem_we, StallM);
    end
    step();
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (mem_addr !== 32'h100 || mem_we !== 1'b0 || StallM !== 1'b0) begin
      failures++;
      $display("FAIL ld_req2 got=%h %b %b exp=100 0 0",
               mem_addr, mem_we, StallM);
    end
    step();
    mem_ready = 1'b0;
    drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (ReadDataW !== 32'hDEAD_BEEF || MemtoRegW !== 1'b1 ||
        RdW !== 4'h5 || RegWriteW !== 1'b1 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL ld_w got=%h %b %h %b %b exp=deadbeef 1 5 1 0",
               ReadDataW, MemtoRegW, RdW, RegWriteW, mem_req);
    end
  endtask

  task automatic test_store;
    drive(0, 0, 0, 1, 4'h7, 32'h20, 32'h1234);
    @(negedge clk);
    checks++;
    if (StallM !== 1'b1) begin
      failures++;
      $display("FAIL st_stall got=%b exp=1", StallM);
    end
    step();
    mem_ready = 1'b1;
    mem_rdata = 32'h5555_5555;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_wdata !== 32'h1234 ||
        mem_addr !== 32'h20 || StallM !== 1'b0 || mem_req !== 1'b1) begin
      failures++;
      $display("FAIL st_bus got=%b %h %h %b %b exp=1 1234 20 0 1",
               mem_we, mem_wdata, mem_addr, StallM, mem_req);
    end
    step();
    mem_ready = 1'b0;
    drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (RegWriteW !== 1'b0 || ReadDataW !== 32'hDEAD_BEEF ||
        mem_req !== 1'b0) begin
      failures++;
      $display("FAIL st_w got=%b %h %b exp=0 deadbeef 0",
               RegWriteW, ReadDataW, mem_req);
    end
  endtask

  task automatic test_timeout;
    int n;
    n = 0;
    mem_ready = 1'b0;
    drive(1, 1, 1, 0, 4'h9, 32'h40, 32'h0);
    @(negedge clk);
    while (StallM === 1'b1 && n < 10) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 4 || mem_req !== 1'b1) begin
      failures++;
      $display("FAIL to_stall_cycles got=%0d %b exp=4 1", n, mem_req);
    end
    step();
    drive(0, 1, 0, 0, 4'h2, 32'h55, 32'h0);
    checks++;
    if (MemErrW !== 1'b1 || RegWriteW !== 1'b0 ||
        PCSrcW !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL to_abort got=%b %b %b %b exp=1 0 0 0",
               MemErrW, RegWriteW, PCSrcW, mem_req);
    end
    @(negedge clk);
    checks++;
    if (StallM !== 1'b0) begin
      failures++;
      $display("FAIL to_next_stall got=%b exp=0", StallM);
    end
    step();
    drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (MemErrW !== 1'b0 || RegWriteW !== 1'b1 ||
        RdW !== 4'h2 || ALUOutW !== 32'h55) begin
      failures++;
      $display("FAIL to_next_w got=%b %b %h %h exp=0 1 2 55",
               MemErrW, RegWriteW, RdW, ALUOutW);
    end
  endtask

  task automatic test_back_to_back;
    int base;
    base = acc_cnt;
    drive(0, 1, 1, 0, 4'h1, 32'h10, 32'h0);
    step();
    mem_ready = 1'b1;
    mem_rdata = 32'hAAAA_0001;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
      failures++;
      $display("FAIL b2b_req_a got=%b %h exp=1 10", mem_req, mem_addr);
    end
    step();
    mem_ready = 1'b0;
    drive(0, 1, 1, 0, 4'h2, 32'h14, 32'h0);
    checks++;
    if (ReadDataW !== 32'hAAAA_0001 || RdW !== 4'h1 ||
        MemtoRegW !== 1'b1) begin
      failures++;
      $display("FAIL b2b_w_a got=%h %h %b exp=aaaa0001 1 1",
               ReadDataW, RdW, MemtoRegW);
    end
    @(negedge clk);
    checks++;
    if (StallM !== 1'b1 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL b2b_detect_b got=%b %b exp=1 0", StallM, mem_req);
    end
    step();
    mem_ready = 1'b1;
    mem_rdata = 32'hBBBB_0002;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h14) begin
      failures++;
      $display("FAIL b2b_req_b got=%b %h exp=1 14", mem_req, mem_addr);
    end
    step();
    mem_ready = 1'b0;
    drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (ReadDataW !== 32'hBBBB_0002 || RdW !== 4'h2) begin
      failures++;
      $display("FAIL b2b_w_b got=%h %h exp=bbbb0002 2", ReadDataW, RdW);
    end
    step();
    step();
    checks++;
    if (acc_cnt - base !== 2) begin
      failures++;
      $display("FAIL b2b_access_count got=%0d exp=2", acc_cnt - base);
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    step();
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_timeout();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/mem_stage_access.md
Name: mem_stage_access

Overview:
- Memory-stage consumer of the Execute->Memory pipeline register outputs (PCSrcM, RegWriteM, MemtoRegM, MemWriteM, RdM, ALUResultM, WriteDataM).
- Performs loads/stores over a req/ready data-memory bus, holds the pipeline via StallM while memory is busy, and registers results into Writeback-stage outputs.
- Non-memory instructions pass through to W in one cycle.

Parameters:
- MAX_WAIT, 16: cycles in REQ without mem_ready before the access is aborted (1..255).
- DATA_W, 32: address/data width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- PCSrcM, RegWriteM, MemtoRegM, MemWriteM  in  1 each  M-stage control
- RdM  in  4  destination register
- ALUResultM  in  DATA_W  address / ALU result
- WriteDataM  in  DATA_W  store data
- mem_req  out  1  bus request (registered)
- mem_we  out  1  1 = store, 0 = load
- mem_addr  out  DATA_W  latched ALUResultM
- mem_wdata  out  DATA_W  latched WriteDataM
- mem_ready  in  1  memory completes the access this cycle
- mem_rdata  in  DATA_W  load data, valid with mem_ready
- StallM  out  1  hold Fetch..Memory stages
- PCSrcW, RegWriteW, MemtoRegW  out  1 each  W-stage control
- RdW  out  4  W-stage destination
- ReadDataW  out  DATA_W  load result
- ALUOutW  out  DATA_W  ALU result for W
- MemErrW  out  1  one-cycle pulse: access timed out

Behaviour:
- memop = MemtoRegM | MemWriteM.
- Reset (async, any state, including mid-access):
  - state = IDLE; mem_req = 0, mem_we = 0.
  - mem_addr, mem_wdata, ReadDataW, ALUOutW = 0; RdW = 0.
  - PCSrcW, RegWriteW, MemtoRegW, MemErrW = 0; wait counter = 0.
- FSM states: IDLE, REQ.
- IDLE, memop=0:
  - W regs load M inputs directly on the next edge (ReadDataW keeps its value); MemErrW = 0.
  - StallM = 0.
- IDLE, memop=1:
  - StallM = 1 (combinational).
  - Latch ctrl/Rd/address/data internally; mem_addr/mem_wdata/mem_we loaded; mem_req <= 1; counter cleared; -> REQ.
  - W control regs load a bubble (PCSrcW = RegWriteW = MemtoRegW = 0).
- REQ, mem_ready=1:
  - StallM = 0 this cycle.
  - Next edge: W regs load the latched ctrl/Rd/ALU result; ReadDataW <= mem_rdata (loads only; stores leave it unchanged).
  - mem_req <= 0; -> IDLE.
- REQ, mem_ready=0, counter < MAX_WAIT-1:
  - StallM = 1; counter++; W bubble.
- REQ, mem_ready=0, counter = MAX_WAIT-1:
  - StallM = 0; abort. Next edge: MemErrW <= 1; W bubble with RegWriteW = 0 and PCSrcW = 0 (side effects suppressed); mem_req <= 0; -> IDLE.
- mem_ready while in IDLE or with mem_req = 0 is ignored.
- Latency:
  - Non-memory: 1 cycle.
  - Memory: minimum 2 cycles (detect + REQ with immediate ready); maximum MAX_WAIT+1.
- Back-to-back memory ops: the second is detected in the IDLE cycle after completion (no overlap, no lost instruction).
- Inputs are held stable by upstream StallM; they are nevertheless latched and never re-sampled during REQ.
- mem_addr, mem_wdata, mem_we are stable for the whole of REQ.
- A load to PC (PCSrcM=1, MemtoRegM=1) propagates PCSrcW only on successful completion.

Decomposition:
- Package mem_stage_pkg:
  - typedef enum logic {IDLE, REQ} mem_state_t.
  - Constant for the default MAX_WAIT.
  - Struct mem_ctrl_t {PCSrc, RegWrite, MemtoReg, MemWrite, Rd}.
- Sub-module mem_wait_ctr: clear/enable/terminal-count counter, width $clog2(MAX_WAIT+1).

Test Plan:
- Reset mid-access: assert reset during REQ with mem_req=1 -> mem_req=0 and StallM=0 immediately; all W outputs 0.
- ALU op: RegWriteM=1, RdM=4'h3, ALUResultM=32'h0000_00AA -> next edge RegWriteW=1, RdW=3, ALUOutW=32'hAA; StallM never high.
- Load with 2-cycle delay: MemtoRegM=1, RegWriteM=1, RdM=5, ALUResultM=32'h100; mem_ready high on the 2nd REQ cycle with rdata=32'hDEADBEEF:
  - mem_addr=32'h100 and mem_we=0 throughout REQ.
  - StallM high for 2 cycles.
  - Then ReadDataW=32'hDEADBEEF, MemtoRegW=1, RdW=5.
- Store with immediate ready: MemWriteM=1, ALUResultM=32'h20, WriteDataM=32'h1234 -> mem_we=1, mem_wdata=32'h1234; StallM high 1 cycle; RegWriteW=0.
- Timeout with MAX_WAIT=4, mem_ready held 0 on a load with RegWriteM=1:
  - StallM high 4 cycles.
  - Then MemErrW pulses 1 cycle; RegWriteW=0; mem_req drops; next instruction proceeds.
- Back-to-back loads to 32'h10 and 32'h14, each with immediate ready:
  - Two distinct requests in order.
  - W receives both results on consecutive completions; no duplicate or missing access.
